// File: rtl/serdes_link_pkg.sv
// Shared types and constants for the SERDES link controller.
package serdes_link_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StTrain,
    StWaitAlign,
    StLinkUp
  } state_e;

  localparam logic [7:0] K28_5 = 8'hBC;

endpackage

// File: rtl/serdes_link_timer.sv
// Clearable saturating up-counter with a terminal-count flag against a runtime compare value.
module serdes_link_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [Width-1:0] tc_val_i,
  output logic             tc_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {Width{1'b1}})) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/serdes_link_ctrl.sv
// SERDES link bring-up controller: K28.5 training, alignment wait, payload pass-through.
// Define SERDES_LINK_ERR_RETRAIN_EN to retrain once err_cnt reaches ERR_THRESH in LINK_UP.
module serdes_link_ctrl
  import serdes_link_pkg::*;
#(
  parameter int unsigned TRAIN_MIN     = 16,
  parameter int unsigned ALIGN_TIMEOUT = 1024,
  parameter int unsigned ERR_THRESH    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       bit_align_done,
  input  logic       rx_error,
  input  logic       payload_valid,
  input  logic [7:0] payload_data,
  output logic       payload_ready,
  output logic       tx_enable,
  output logic [7:0] tx_data,
  output logic       tx_k_char,
  output logic       link_up,
  output logic       link_fail,
  output logic [7:0] err_cnt
);

  localparam int unsigned TmrMax = (TRAIN_MIN > ALIGN_TIMEOUT) ? TRAIN_MIN : ALIGN_TIMEOUT;
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);
  localparam logic [TmrW-1:0] TrainTc   = TmrW'((TRAIN_MIN > 0) ? TRAIN_MIN - 1 : 0);
  localparam logic [TmrW-1:0] TimeoutTc = TmrW'((ALIGN_TIMEOUT > 0) ? ALIGN_TIMEOUT - 1 : 0);

`ifdef SERDES_LINK_ERR_RETRAIN_EN
  localparam bit RetrainEn = 1'b1;
`else
  localparam bit RetrainEn = 1'b0;
`endif

  state_e     state_d, state_q;
  logic       tx_enable_d, tx_enable_q;
  logic [7:0] tx_data_d, tx_data_q;
  logic       tx_k_char_d, tx_k_char_q;
  logic       link_up_d, link_up_q;
  logic       link_fail_d, link_fail_q;
  logic [7:0] err_cnt_d, err_cnt_q;

  logic            tmr_tc;
  logic [TmrW-1:0] tmr_tc_val;
  logic [7:0]      err_inc;
  logic            err_hit;
  logic            accept;

  assign tmr_tc_val = (state_q == StTrain) ? TrainTc : TimeoutTc;

  serdes_link_timer #(
    .Width (TmrW)
  ) u_timer (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .clr_i    (state_d != state_q),
    .en_i     ((state_q == StTrain) || (state_q == StWaitAlign)),
    .tc_val_i (tmr_tc_val),
    .tc_o     (tmr_tc)
  );

  assign err_inc = err_cnt_q + {7'd0, (rx_error && (err_cnt_q != 8'hFF))};
  assign err_hit = RetrainEn && ({24'd0, err_inc} >= ERR_THRESH);
  // A byte offered in the cycle that leaves LINK_UP is dropped, like one cut off by reset.
  assign accept  = (state_q == StLinkUp) && payload_valid;

  always_comb begin
    state_d     = state_q;
    link_fail_d = 1'b0;
    if (!enable) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StTrain;
        StTrain: if (tmr_tc) state_d = StWaitAlign;
        StWaitAlign: begin
          if (bit_align_done) begin
            state_d = StLinkUp;
          end else if (tmr_tc) begin
            state_d     = StTrain;
            link_fail_d = 1'b1;
          end
        end
        StLinkUp: if (!bit_align_done || err_hit) state_d = StTrain;
        default:  state_d = StIdle;
      endcase
    end

    err_cnt_d = err_cnt_q;
    if (!enable) begin
      err_cnt_d = '0;
    end else if ((state_d == StLinkUp) && (state_q != StLinkUp)) begin
      err_cnt_d = '0;
    end else if (state_q == StLinkUp) begin
      err_cnt_d = err_inc;
    end

    // Outputs are computed from the next state so they line up with it once registered.
    tx_enable_d = (state_d != StIdle);
    link_up_d   = (state_d == StLinkUp);
    tx_data_d   = '0;
    tx_k_char_d = 1'b0;
    unique case (state_d)
      StTrain, StWaitAlign: begin
        tx_data_d   = K28_5;
        tx_k_char_d = 1'b1;
      end
      StLinkUp: begin
        if (accept) begin
          tx_data_d = payload_data;
        end else begin
          tx_data_d   = K28_5;
          tx_k_char_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      tx_enable_q <= 1'b0;
      tx_data_q   <= '0;
      tx_k_char_q <= 1'b0;
      link_up_q   <= 1'b0;
      link_fail_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      tx_enable_q <= tx_enable_d;
      tx_data_q   <= tx_data_d;
      tx_k_char_q <= tx_k_char_d;
      link_up_q   <= link_up_d;
      link_fail_q <= link_fail_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign payload_ready = link_up_q;
  assign tx_enable     = tx_enable_q;
  assign tx_data       = tx_data_q;
  assign tx_k_char     = tx_k_char_q;
  assign link_up       = link_up_q;
  assign link_fail     = link_fail_q;
  assign err_cnt       = err_cnt_q;

endmodule
